// File: rtl/pf_multi.sv
// Multi-channel pulse former: per-channel edge detect (rise/fall/both) that emits
// a fixed PW-cycle registered pulse, with optional retrigger and a missed-edge flag.
module pf_multi #(
  parameter int CH     = 4,
  parameter int PW     = 1,
  parameter int EDGE   = 0,
  parameter int RETRIG = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] in,
  input  logic [CH-1:0] en,
  output logic [CH-1:0] q,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] miss
);

  localparam int             CW   = $clog2(PW + 1);
  localparam logic [CW-1:0]  PW_C = CW'(PW);

  generate
    if (PW < 1 || PW > 65535 || CH < 1 || CH > 32 || EDGE < 0 || EDGE > 2) begin : g_bad_param
      $error("pf_multi: illegal parameters CH=%0d PW=%0d EDGE=%0d", CH, PW, EDGE);
    end
  endgenerate

  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];
  logic [CH-1:0] prev_q;
  logic [CH-1:0] q_q, q_d;
  logic [CH-1:0] miss_q, miss_d;
  logic [CH-1:0] rise_s, fall_s, sel_s, det_s;

  always_comb begin
    rise_s = in & ~prev_q;
    fall_s = ~in & prev_q;
    if (EDGE == 0) begin
      sel_s = rise_s;
    end else if (EDGE == 1) begin
      sel_s = fall_s;
    end else begin
      sel_s = rise_s | fall_s;
    end
    det_s = sel_s & en;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      miss_d[i] = 1'b0;
      if (det_s[i]) begin
        if (cnt_q[i] == '0) begin
          cnt_d[i] = PW_C;
        end else if (RETRIG != 0) begin
          cnt_d[i] = PW_C;
        end else begin
          // Edge dropped while busy: the pulse keeps counting down undisturbed.
          cnt_d[i]  = cnt_q[i] - CW'(1);
          miss_d[i] = 1'b1;
        end
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      q_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      q_q    <= '0;
      miss_q <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      prev_q <= in;
      q_q    <= q_d;
      miss_q <= miss_d;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign q    = q_q;
  assign busy = q_q;
  assign miss = miss_q;

endmodule
